// File: rtl/mmio_port_bank_if.sv
// CPU data-bus slice seen by the MMIO port bank: word address, write data/enable,
// plus the bank's hit flag and combinational read data.
interface mmio_port_bank_if;
  logic [14:0] address;
  logic [15:0] in;
  logic        load;
  logic        hit;
  logic [15:0] out;

  modport master (output address, in, load, input hit, out);
  modport slave  (input address, in, load, output hit, out);
endinterface

// File: rtl/mmio_port_bank.sv
// Bank of NPORTS bidirectional GPIO ports on the CPU data bus: output latch, direction,
// synchronised pin readback, atomic set/clear and armed edge capture into an irq line.
module mmio_port_bank #(
  parameter int          NPORTS = 4,
  parameter int          WIDTH  = 16,
  parameter logic [14:0] BASE   = 15'h7000
) (
  input  logic                     clk,
  input  logic                     reset,
  mmio_port_bank_if.slave          bus,
  input  logic [NPORTS*WIDTH-1:0]  pin_in,
  output logic [NPORTS*WIDTH-1:0]  port_out,
  output logic [NPORTS*WIDTH-1:0]  port_oe,
  output logic                     irq
);

  localparam int          NB    = NPORTS * WIDTH;
  localparam logic [15:0] LIMIT = {1'b0, BASE} + 16'(8 * NPORTS);

  logic [NB-1:0]    out_q, dir_q, rise_en_q, fall_en_q, flag_q;
  logic [NB-1:0]    s1_q, s2_q, prev_q;
  logic [NB-1:0]    edge_set, flag_clr;
  logic [1:0]       arm_q;
  logic [3:0]       sel_port;
  logic [2:0]       sel_reg;
  logic             wr;
  logic [WIDTH-1:0] wd, field;
  logic [15:0]      rd;

  // BASE is 128-word aligned, so the low address bits index port and register directly.
  assign bus.hit  = ({1'b0, bus.address} >= {1'b0, BASE}) && ({1'b0, bus.address} < LIMIT);
  assign sel_port = bus.address[6:3];
  assign sel_reg  = bus.address[2:0];
  assign wr       = bus.load && bus.hit;
  assign wd       = bus.in[WIDTH-1:0];

  // Edges are ignored until the arm counter saturates, masking pins high at reset release.
  assign edge_set = (arm_q == 2'd3)
                  ? ((s2_q & ~prev_q & rise_en_q) | (~s2_q & prev_q & fall_en_q))
                  : '0;

  always_comb begin
    flag_clr = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (wr && sel_port == 4'(i) && sel_reg == 3'd5)
        flag_clr[i*WIDTH +: WIDTH] = wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      flag_q    <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      arm_q     <= '0;
      irq       <= 1'b0;
    end else begin
      s1_q   <= pin_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (arm_q != 2'd3)
        arm_q <= arm_q + 2'd1;
      flag_q <= (flag_q & ~flag_clr) | edge_set;
      irq    <= |flag_q;
      for (int i = 0; i < NPORTS; i++) begin
        if (wr && sel_port == 4'(i)) begin
          case (sel_reg)
            3'd0: out_q[i*WIDTH +: WIDTH]     <= wd;
            3'd1: dir_q[i*WIDTH +: WIDTH]     <= wd;
            3'd3: rise_en_q[i*WIDTH +: WIDTH] <= wd;
            3'd4: fall_en_q[i*WIDTH +: WIDTH] <= wd;
            3'd6: out_q[i*WIDTH +: WIDTH]     <= out_q[i*WIDTH +: WIDTH] | wd;
            3'd7: out_q[i*WIDTH +: WIDTH]     <= out_q[i*WIDTH +: WIDTH] & ~wd;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    field = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (sel_port == 4'(i)) begin
        case (sel_reg)
          3'd0:    field = out_q[i*WIDTH +: WIDTH];
          3'd1:    field = dir_q[i*WIDTH +: WIDTH];
          3'd2:    field = s2_q[i*WIDTH +: WIDTH];
          3'd3:    field = rise_en_q[i*WIDTH +: WIDTH];
          3'd4:    field = fall_en_q[i*WIDTH +: WIDTH];
          3'd5:    field = flag_q[i*WIDTH +: WIDTH];
          default: field = '0;
        endcase
      end
    end
    rd              = '0;
    rd[WIDTH-1:0]   = field;
  end

  assign bus.out  = bus.hit ? rd : 16'h0000;
  assign port_out = out_q;
  assign port_oe  = dir_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed bench for mmio_port_bank: a default 4x16 bank and a narrow 2x8 bank on one clock.
module tb_mmio_port_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pin_a;
  logic [63:0] port_out_a, port_oe_a;
  logic        irq_a;
  logic [15:0] pin_b;
  logic [15:0] port_out_b, port_oe_b;
  logic        irq_b;
  logic [15:0] d;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  mmio_port_bank_if bus_a ();
  mmio_port_bank_if bus_b ();

  mmio_port_bank #(.NPORTS(4), .WIDTH(16), .BASE(15'h7000)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .pin_in(pin_a),
    .port_out(port_out_a), .port_oe(port_oe_a), .irq(irq_a));

  mmio_port_bank #(.NPORTS(2), .WIDTH(8), .BASE(15'h7000)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .pin_in(pin_b),
    .port_out(port_out_b), .port_oe(port_oe_b), .irq(irq_b));

  typedef struct {
    logic        we;
    logic [14:0] waddr;
    logic [15:0] wdata;
    logic [14:0] raddr;
    logic        exp_hit;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wr_a(input logic [14:0] a, input logic [15:0] v);
    @(negedge clk);
    bus_a.address = a; bus_a.in = v; bus_a.load = 1'b1;
    @(posedge clk); #1;
    bus_a.load = 1'b0;
  endtask

  task automatic wr_b(input logic [14:0] a, input logic [15:0] v);
    @(negedge clk);
    bus_b.address = a; bus_b.in = v; bus_b.load = 1'b1;
    @(posedge clk); #1;
    bus_b.load = 1'b0;
  endtask

  task automatic rd_a(input logic [14:0] a, output logic [15:0] v);
    bus_a.address = a; bus_a.load = 1'b0;
    #1 v = bus_a.out;
  endtask

  task automatic rd_b(input logic [14:0] a, output logic [15:0] v);
    bus_b.address = a; bus_b.load = 1'b0;
    #1 v = bus_b.out;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 15'h7009, 16'h00FF, 15'h7009, 1'b1, 16'h00FF};
    vecs[1]  = '{1'b1, 15'h7008, 16'h1234, 15'h7008, 1'b1, 16'h1234};
    vecs[2]  = '{1'b1, 15'h700E, 16'h0001, 15'h7008, 1'b1, 16'h1235};
    vecs[3]  = '{1'b1, 15'h700F, 16'h0004, 15'h7008, 1'b1, 16'h1231};
    vecs[4]  = '{1'b0, 15'h0000, 16'h0000, 15'h700E, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 15'h0000, 16'h0000, 15'h700F, 1'b1, 16'h0000};
    vecs[6]  = '{1'b1, 15'h700A, 16'hFFFF, 15'h700A, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 15'h7013, 16'hA5A5, 15'h7013, 1'b1, 16'hA5A5};
    vecs[8]  = '{1'b1, 15'h701C, 16'h5A5A, 15'h701C, 1'b1, 16'h5A5A};
    vecs[9]  = '{1'b0, 15'h0000, 16'h0000, 15'h7020, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 15'h7080, 16'hFFFF, 15'h7000, 1'b1, 16'h0000};
    vecs[11] = '{1'b0, 15'h0000, 16'h0000, 15'h6FFF, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 15'h0000, 16'h0000, 15'h701F, 1'b1, 16'h0000};

    reset = 1'b0;
    pin_a = '1;
    pin_b = 16'h00FF;
    bus_a.address = '0; bus_a.in = '0; bus_a.load = 1'b0;
    bus_b.address = '0; bus_b.in = '0; bus_b.load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Pins high across reset release must not raise flags.
    for (int p = 0; p < 4; p++) begin
      rd_a(15'(15'h7005 + 8*p), d); check($sformatf("reset_flag%0d", p), d, 16'h0000);
      rd_a(15'(15'h7002 + 8*p), d); check($sformatf("reset_pin%0d", p), d, 16'hFFFF);
    end
    check("reset_irq", irq_a, 1'b0);
    check("reset_port_out", port_out_a, 64'h0);
    check("reset_port_oe", port_oe_a, 64'h0);

    rd_b(15'h7002, d); check("b_pin0", d, 16'h00FF);
    rd_b(15'h700A, d); check("b_pin1", d, 16'h0000);
    rd_b(15'h7010, d); check("b_out_range_out", d, 16'h0000);
    check("b_out_range_hit", bus_b.hit, 1'b0);
    wr_b(15'h7010, 16'hFFFF);
    wr_b(15'h7080, 16'hFFFF);
    rd_b(15'h7000, d); check("b_stray_write_out0", d, 16'h0000);
    check("b_stray_port_out", port_out_b, 16'h0000);
    wr_b(15'h7000, 16'hABCD);
    rd_b(15'h7000, d); check("b_out0_trunc", d, 16'h00CD);
    check("b_port_out", port_out_b, 16'h00CD);
    rd_b(15'h700F, d); check("b_last_word_hit", bus_b.hit, 1'b1);

    @(negedge clk) pin_a = '0;
    repeat (4) @(posedge clk);
    #1;

    for (int k = 0; k < 13; k++) begin
      if (vecs[k].we) wr_a(vecs[k].waddr, vecs[k].wdata);
      rd_a(vecs[k].raddr, d);
      check($sformatf("vec%0d_out", k), d, vecs[k].exp_out);
      check($sformatf("vec%0d_hit", k), bus_a.hit, vecs[k].exp_hit);
    end
    check("port1_out", port_out_a[31:16], 16'h1231);
    check("port1_oe", port_oe_a[31:16], 16'h00FF);
    check("port0_out", port_out_a[15:0], 16'h0000);

    // Rising edge latency on port 0 bit 0.
    wr_a(15'h7003, 16'h0001);
    @(negedge clk) pin_a[0] = 1'b1;
    @(posedge clk); #1;
    rd_a(15'h7002, d); check("rise_pin_n", d, 16'h0000);
    @(posedge clk); #1;
    rd_a(15'h7002, d); check("rise_pin_n1", d, 16'h0001);
    rd_a(15'h7005, d); check("rise_flag_n1", d, 16'h0000);
    @(posedge clk); #1;
    rd_a(15'h7005, d); check("rise_flag_n2", d, 16'h0001);
    check("rise_irq_n2", irq_a, 1'b0);
    @(posedge clk); #1;
    check("rise_irq_n3", irq_a, 1'b1);
    wr_a(15'h7005, 16'h0001);
    rd_a(15'h7005, d); check("w1c_flag", d, 16'h0000);
    check("w1c_irq_lag", irq_a, 1'b1);
    @(posedge clk); #1;
    check("w1c_irq_drop", irq_a, 1'b0);

    // Falling edge on port 3 bit 3 colliding with a W1C of the same bit.
    @(negedge clk) pin_a[51] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) pin_a[51] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd_a(15'h701D, d); check("fall_flag", d, 16'h0008);
    @(negedge clk) pin_a[51] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) pin_a[51] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    wr_a(15'h701D, 16'h0008);
    rd_a(15'h701D, d); check("set_wins", d, 16'h0008);
    wr_a(15'h701D, 16'h0008);
    rd_a(15'h701D, d); check("plain_w1c", d, 16'h0000);

    // Asynchronous reset with live state.
    @(negedge clk) pin_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) pin_a[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd_a(15'h7005, d); check("pre_reset_flag", d, 16'h0001);
    wr_a(15'h7000, 16'hFFFF);
    rd_a(15'h7000, d); check("pre_reset_out0", d, 16'hFFFF);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_port_out", port_out_a, 64'h0);
    check("async_port_oe", port_oe_a, 64'h0);
    check("async_irq", irq_a, 1'b0);
    check("async_out", bus_a.out, 16'h0000);
    check("async_b_port_out", port_out_b, 16'h0000);
    pin_a = '0;

    // Edge reaching s2 before the bank is armed must not set FLAG.
    @(negedge clk);
    reset = 1'b1;
    pin_a[0] = 1'b1;
    bus_a.address = 15'h7003; bus_a.in = 16'h0001; bus_a.load = 1'b1;
    @(posedge clk); #1;
    bus_a.load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rd_a(15'h7003, d); check("arm_rise_en", d, 16'h0001);
    rd_a(15'h7005, d); check("arm_no_flag", d, 16'h0000);
    check("arm_no_irq", irq_a, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
